// File: rtl/img_capture_ctrl_if.sv
// Bundle between the audio/FFT datapath, the image capture sequencer and the
// two display block-memory write ports.
//   master : datapath side, drives frame/sample/bin strobes, sees memory writes
//   slave  : the sequencer itself
interface img_capture_ctrl_if;
  logic       frameSync;
  logic       freeze;
  logic       sampleValid;
  logic [7:0] sampleData;
  logic       binValid;
  logic [7:0] binData;
  logic       binLast;
  logic       enaTime;
  logic       weaTime;
  logic [9:0] addraTime;
  logic [7:0] dinaTime;
  logic       weaFreq;
  logic [9:0] addraFreq;
  logic [7:0] dinaFreq;
  logic       busyTime;
  logic       trigAuto;

  modport master (
    output frameSync, freeze, sampleValid, sampleData, binValid, binData, binLast,
    input  enaTime, weaTime, addraTime, dinaTime, weaFreq, addraFreq, dinaFreq,
           busyTime, trigAuto
  );

  modport slave (
    input  frameSync, freeze, sampleValid, sampleData, binValid, binData, binLast,
    output enaTime, weaTime, addraTime, dinaTime, weaFreq, addraFreq, dinaFreq,
           busyTime, trigAuto
  );
endinterface

// File: rtl/img_capture_ctrl.sv
// Write-side sequencer for the time- and frequency-domain display memories.
// Each video frame may arm one triggered capture of decimated audio samples
// into the time memory and one aligned FFT magnitude frame into the freq memory.
// Ports:
//   ck100MHz : system clock, rising edge
//   rstn     : synchronous active-low reset
//   bus      : slave side of img_capture_ctrl_if (strobes in, memory writes out)
// All outputs are registered; a write pulse follows its strobe by one cycle.
module img_capture_ctrl #(
  parameter int unsigned cstHorSize     = 640,
  parameter int unsigned cstDecim       = 1,
  parameter int unsigned cstTrigLevel   = 128,
  parameter int unsigned cstTrigTimeout = 2048,
  parameter int unsigned cstFreqBins    = 512
) (
  input logic               ck100MHz,
  input logic               rstn,
  img_capture_ctrl_if.slave bus
);

  localparam int unsigned DecW = (cstDecim > 1) ? $clog2(cstDecim) : 1;
  localparam int unsigned ToW  = $clog2(cstTrigTimeout);

  localparam logic [DecW-1:0] DecLast   = DecW'(cstDecim - 1);
  localparam logic [ToW-1:0]  ToLast    = ToW'(cstTrigTimeout - 1);
  localparam logic [9:0]      LastAddr  = 10'(cstHorSize - 1);
  localparam logic [7:0]      TrigLevel = 8'(cstTrigLevel);
  localparam logic [10:0]     FreqBins  = 11'(cstFreqBins);

  localparam logic [1:0] WaitSync = 2'd0;
  localparam logic [1:0] Arm      = 2'd1;
  localparam logic [1:0] Capture  = 2'd2;

  localparam logic [1:0] FIdle  = 2'd0;
  localparam logic [1:0] FAlign = 2'd1;
  localparam logic [1:0] FWrite = 2'd2;

  // Time path
  logic [1:0]      tStateQ, tStateD;
  logic [DecW-1:0] decimQ, decimD;
  logic [ToW-1:0]  toCntQ, toCntD;
  logic [7:0]      prevQ, prevD;
  logic            prevValidQ, prevValidD;
  logic            weaTimeQ, weaTimeD;
  logic [9:0]      addrTimeQ, addrTimeD;
  logic [7:0]      dinTimeQ, dinTimeD;
  logic            trigAutoQ, trigAutoD;
  logic            busyQ;
  logic            accept, levelTrig;

  // Freq path
  logic [1:0]      fStateQ, fStateD;
  logic [9:0]      idxQ, idxD;
  logic            weaFreqQ, weaFreqD;
  logic [9:0]      addrFreqQ, addrFreqD;
  logic [7:0]      dinFreqQ, dinFreqD;

  always_comb begin
    tStateD    = tStateQ;
    decimD     = decimQ;
    toCntD     = toCntQ;
    prevD      = prevQ;
    prevValidD = prevValidQ;
    weaTimeD   = 1'b0;
    addrTimeD  = addrTimeQ;
    dinTimeD   = dinTimeQ;
    trigAutoD  = trigAutoQ;
    accept     = 1'b0;
    levelTrig  = 1'b0;
    case (tStateQ)
      WaitSync: begin
        if (bus.frameSync && !bus.freeze) begin
          tStateD    = Arm;
          decimD     = '0;
          toCntD     = '0;
          prevValidD = 1'b0;
        end
      end
      Arm, Capture: begin
        if (bus.sampleValid) begin
          decimD = (decimQ == DecLast) ? '0 : decimQ + DecW'(1);
        end
        accept    = bus.sampleValid && (decimQ == '0);
        levelTrig = prevValidQ && (prevQ < TrigLevel) && (bus.sampleData >= TrigLevel);
        if (accept) begin
          if (tStateQ == Capture) begin
            weaTimeD  = 1'b1;
            dinTimeD  = bus.sampleData;
            addrTimeD = addrTimeQ + 10'd1;
            if (addrTimeD == LastAddr) tStateD = WaitSync;
          end else if (levelTrig || (toCntQ == ToLast)) begin
            weaTimeD  = 1'b1;
            dinTimeD  = bus.sampleData;
            addrTimeD = '0;
            trigAutoD = !levelTrig;
            // A one-sample window is complete as soon as address 0 is written.
            tStateD   = (LastAddr == 10'd0) ? WaitSync : Capture;
          end else begin
            toCntD     = toCntQ + ToW'(1);
            prevD      = bus.sampleData;
            prevValidD = 1'b1;
          end
        end
      end
      default: tStateD = WaitSync;
    endcase
  end

  always_comb begin
    fStateD   = fStateQ;
    idxD      = idxQ;
    weaFreqD  = 1'b0;
    addrFreqD = addrFreqQ;
    dinFreqD  = dinFreqQ;
    case (fStateQ)
      FIdle: begin
        if (bus.frameSync && !bus.freeze) begin
          // A frame boundary coinciding with the arm means the next bin is bin 0.
          fStateD = (bus.binValid && bus.binLast) ? FWrite : FAlign;
          idxD    = '0;
        end
      end
      FAlign: begin
        if (bus.binValid && bus.binLast) begin
          fStateD = FWrite;
          idxD    = '0;
        end
      end
      FWrite: begin
        if (bus.binValid) begin
          if ({1'b0, idxQ} < FreqBins) begin
            weaFreqD  = 1'b1;
            addrFreqD = idxQ;
            dinFreqD  = bus.binData;
          end
          if (idxQ != 10'd1023) idxD = idxQ + 10'd1;
          if (bus.binLast) fStateD = FIdle;
        end
      end
      default: fStateD = FIdle;
    endcase
  end

  always_ff @(posedge ck100MHz) begin
    if (!rstn) begin
      tStateQ    <= WaitSync;
      decimQ     <= '0;
      toCntQ     <= '0;
      prevQ      <= '0;
      prevValidQ <= 1'b0;
      weaTimeQ   <= 1'b0;
      addrTimeQ  <= '0;
      dinTimeQ   <= '0;
      trigAutoQ  <= 1'b0;
      busyQ      <= 1'b0;
      fStateQ    <= FIdle;
      idxQ       <= '0;
      weaFreqQ   <= 1'b0;
      addrFreqQ  <= '0;
      dinFreqQ   <= '0;
    end else begin
      tStateQ    <= tStateD;
      decimQ     <= decimD;
      toCntQ     <= toCntD;
      prevQ      <= prevD;
      prevValidQ <= prevValidD;
      weaTimeQ   <= weaTimeD;
      addrTimeQ  <= addrTimeD;
      dinTimeQ   <= dinTimeD;
      trigAutoQ  <= trigAutoD;
      busyQ      <= (tStateD != WaitSync);
      fStateQ    <= fStateD;
      idxQ       <= idxD;
      weaFreqQ   <= weaFreqD;
      addrFreqQ  <= addrFreqD;
      dinFreqQ   <= dinFreqD;
    end
  end

  assign bus.enaTime   = weaTimeQ;
  assign bus.weaTime   = weaTimeQ;
  assign bus.addraTime = addrTimeQ;
  assign bus.dinaTime  = dinTimeQ;
  assign bus.weaFreq   = weaFreqQ;
  assign bus.addraFreq = addrFreqQ;
  assign bus.dinaFreq  = dinFreqQ;
  assign bus.busyTime  = busyQ;
  assign bus.trigAuto  = trigAutoQ;

endmodule
